axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Shares the core's single AXI4 read-address/read-data channel pair between the instruction fetcher and the data-memory load path. It accepts one burst request at a time from either requester, drives the AR channel, and steers R beats back to the owning requester until `rlast`. Exactly one burst is outstanding at any time. The block sits between the fetch/MEM stages and the top-level `m_axi_ar*`/`m_axi_r*` ports.

## Interface
- `ID_WIDTH`, 13, AXI ID width
- `ADDR_WIDTH`, 64, address width
- `DATA_WIDTH`, 64, data width
- `IF_ARID`, 0, ARID used for fetch bursts
- `DM_ARID`, 1, ARID used for data bursts

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `if_req` / `dm_req`  in  1  burst request; held with addr/len until the matching gnt
- `if_addr` / `dm_addr`  in  ADDR_WIDTH  burst start address
- `if_len` / `dm_len`  in  8  AXI arlen (beats−1)
- `if_gnt` / `dm_gnt`  out  1  one-cycle pulse on the AR handshake for that requester
- `if_rvalid` / `dm_rvalid`  out  1  beat valid to owner
- `if_rdata` / `dm_rdata`  out  DATA_WIDTH  beat data (`m_axi_rdata` pass-through)
- `if_rlast` / `dm_rlast`  out  1  last beat of burst
- `if_rresp` / `dm_rresp`  out  2  beat response
- `m_axi_arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arcache`, `arprot`, `arvalid`  out  AXI AR channel
- `m_axi_arready`  in  1
- `m_axi_rid`, `rdata`, `rresp`, `rlast`, `rvalid`  in  AXI R channel
- `m_axi_rready`  out  1
- `proto_err`  out  1  sticky; set on RID mismatch or early/late `rlast`; cleared only by reset

## Operation
- FSM states:
  - IDLE: if any `req` is set, select the winner, register its addr, len, ID and owner, then go to ADDR.
  - ADDR: `arvalid`=1. On `arready`, pulse the owner's `gnt` and go to DATA.
  - DATA: `rready`=1. Forward each beat. On `rvalid && rlast`, go to IDLE.
- Default arbitration is fixed priority: `dm_req` wins over `if_req`.
- AR fields:
  - `arsize`=3'b011 and `arburst`=2'b01 (INCR).
  - `arlock`=0 and `arcache`=0.
  - `arprot`=3'b100 for fetch and 3'b000 for data.
  - `arid` is `IF_ARID` or `DM_ARID` according to owner.
- AR outputs are registered and hold stable while `arvalid`=1 and `arready`=0.
- Beat routing: `x_rvalid = m_axi_rvalid && state==DATA && owner==x`. The non-owner's `rvalid` is 0. Data, resp and last are pass-through to both requesters.
- Requesters always accept beats; there is no backpressure toward the slave other than state.
- An 8-bit beat counter resets to 0 on entering DATA and increments on each beat.
  - `rlast` arriving with count≠len sets `proto_err`.
  - count==len arriving without `rlast` sets `proto_err`.
  - On these errors the FSM still waits for `rlast`.
- A RID that does not match the registered ID sets `proto_err`. The beat is still forwarded.
- `rvalid` seen in IDLE or ADDR is ignored (`rready`=0).

## Timing
- Reset values:
  - state=IDLE.
  - All `m_axi_ar*`=0, `rready`=0.
  - All `gnt` and `rvalid`=0.
  - `proto_err`=0, owner=IF, RR pointer=IF.
- Minimum latency from `req` to `arvalid` is 1 cycle (IDLE sampled at edge N, `arvalid` high after edge N).
- `gnt` is combinational in the AR-handshake cycle.
- Back-to-back bursts: after `rlast`, there is 1 IDLE cycle before the next ADDR, so the bubble is 2 cycles from the last beat to the next `arvalid`.
- Simultaneous `if_req` and `dm_req` in IDLE: resolved by the arbitration policy. The loser keeps `req` asserted and is served next.
- A requester dropping `req` while in ADDR does not cancel the burst; the burst completes. Requesters must not drop `req`.
- Reset mid-burst returns to IDLE immediately and deasserts all outputs. No AXI cleanup is performed.

## Configuration
- `AXI_RD_ARB_RR_EN` defined: round-robin arbitration. On a tie, the requester not granted last wins. The pointer updates on each `gnt`.
- Undefined: fixed priority, `dm` over `if`. The pointer logic is absent.

## Test plan
- Single fetch: `if_req`, addr 0x8000_0000, len 7, `arready` after 2 cycles.
  - `arid`=0, `arprot`=3'b100, `arlen`=7.
  - `if_gnt` pulses once.
  - 8 beats reach `if_rvalid`, `dm_rvalid` stays 0, and the FSM returns to IDLE.
- Simultaneous `if_req` and `dm_req` with the macro undefined: `dm` is granted first (`arid`=1, `arprot`=0), then `if`.
  - With `AXI_RD_ARB_RR_EN`, repeat the tie twice; grants alternate.
- AR stall: hold `arready`=0 for 5 cycles. All AR fields stay constant and `arvalid` stays 1.
- Protocol error: len 3 with `rlast` on beat 2 → `proto_err`=1 and stays set; FSM goes to IDLE.
  - A separate burst with RID 5 → `proto_err` is set.
- Reset mid-burst: assert `reset` during beat 3 of 8 → all outputs 0 and state IDLE in the same cycle.
  - A new `if_req` after release → normal burst.
- Stray `rvalid` in IDLE → `rready`=0 and no requester `rvalid`.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 AR/R channel pair between the instruction
// fetcher (IF) and the data-memory load path (DM). One burst outstanding.
// Optional feature: define AXI_RD_ARB_RR_EN for round-robin arbitration;
// otherwise DM has fixed priority over IF.
module axi_rd_arbiter #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int IF_ARID    = 0,
  parameter int DM_ARID    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [7:0]            if_len,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_rlast,
  output logic [1:0]            if_rresp,
  input  logic                  dm_req,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [7:0]            dm_len,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_rlast,
  output logic [1:0]            dm_rresp,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  proto_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state, state_nxt;
  logic       own_dm;   // burst owner: 0 = IF, 1 = DM
  logic       pick_dm;  // arbitration winner in IDLE
  logic       any_req;
  logic       ar_hs;
  logic       beat;
  logic [7:0] cnt;

  assign any_req = if_req | dm_req;
  assign ar_hs   = (state == ADDR) && m_axi_arready;
  assign beat    = (state == DATA) && m_axi_rvalid;

`ifdef AXI_RD_ARB_RR_EN
  logic last_dm;  // requester granted most recently
  assign pick_dm = dm_req && (!if_req || !last_dm);

  // Round-robin pointer follows every grant
  always_ff @(posedge clk or posedge reset)
    if (reset)      last_dm <= 1'b0;
    else if (ar_hs) last_dm <= own_dm;
`else
  assign pick_dm = dm_req;
`endif

  // State register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (m_axi_arready) state_nxt = DATA;
      DATA:    if (m_axi_rvalid && m_axi_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered AR fields and channel handshake signals; fields captured once
  // in IDLE so they hold steady through any AR stall
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      own_dm        <= 1'b0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      m_axi_arprot  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        own_dm        <= pick_dm;
        m_axi_arid    <= pick_dm ? ID_WIDTH'(DM_ARID) : ID_WIDTH'(IF_ARID);
        m_axi_araddr  <= pick_dm ? dm_addr : if_addr;
        m_axi_arlen   <= pick_dm ? dm_len : if_len;
        m_axi_arsize  <= 3'b011;
        m_axi_arburst <= 2'b01;
        m_axi_arprot  <= pick_dm ? 3'b000 : 3'b100;
      end
      m_axi_arvalid <= (state_nxt == ADDR);
      m_axi_rready  <= (state_nxt == DATA);
    end

  // Beat counter, cleared as the burst enters DATA
  always_ff @(posedge clk or posedge reset)
    if (reset)      cnt <= '0;
    else if (ar_hs) cnt <= '0;
    else if (beat)  cnt <= cnt + 8'd1;

  // Sticky protocol error: wrong RID, early rlast or missing rlast
  always_ff @(posedge clk or posedge reset)
    if (reset) proto_err <= 1'b0;
    else if (beat && ((m_axi_rid != m_axi_arid) ||
                      ( m_axi_rlast && cnt != m_axi_arlen) ||
                      (!m_axi_rlast && cnt == m_axi_arlen)))
      proto_err <= 1'b1;

  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0000;

  assign if_gnt    = ar_hs && !own_dm;
  assign dm_gnt    = ar_hs &&  own_dm;
  assign if_rvalid = beat  && !own_dm;
  assign dm_rvalid = beat  &&  own_dm;

  assign if_rdata = m_axi_rdata;
  assign dm_rdata = m_axi_rdata;
  assign if_rlast = m_axi_rlast;
  assign dm_rlast = m_axi_rlast;
  assign if_rresp = m_axi_rresp;
  assign dm_rresp = m_axi_rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus random
// bursts against a transaction-level model of arbitration and routing.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req;
  logic [63:0] if_addr, dm_addr;
  logic [7:0]  if_len, dm_len;
  logic        if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rlast, dm_rlast;
  logic [63:0] if_rdata, dm_rdata;
  logic [1:0]  if_rresp, dm_rresp;
  logic [12:0] arid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        arlock, arvalid, arready;
  logic [3:0]  arcache;
  logic [12:0] rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, proto_err;

  int checks = 0;
  int fails  = 0;
  bit last_was_if = 1'b1;  // model: requester granted most recently

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_len(if_len), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rlast(if_rlast), .if_rresp(if_rresp),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_len(dm_len), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_rlast(dm_rlast), .dm_rresp(dm_rresp),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model of the arbitration policy
  function automatic bit model_pick_dm(input bit i, input bit d);
`ifdef AXI_RD_ARB_RR_EN
    return d && (!i || last_was_if);
`else
    return d;
`endif
  endfunction

  task automatic chk_quiet(input string tag);
    check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    check({tag, "_arfields"}, {arid, arlen, arsize, arburst, arprot, arlock, arcache}, 64'd0);
    check({tag, "_araddr"}, araddr, 64'd0);
    check({tag, "_rready"}, 64'(rready), 64'd0);
    check({tag, "_gnt"}, {if_gnt, dm_gnt}, 64'd0);
    check({tag, "_rvalid"}, {if_rvalid, dm_rvalid}, 64'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    arready = 1'b0; rvalid = 1'b0;
    #1;
  endtask

  task automatic chk_ar(input bit dm, input logic [63:0] a, input logic [7:0] l);
    check("arvalid", 64'(arvalid), 64'd1);
    check("arid", 64'(arid), dm ? 64'd1 : 64'd0);
    check("araddr", araddr, a);
    check("arlen", 64'(arlen), 64'(l));
    check("arprot", 64'(arprot), dm ? 64'd0 : 64'd4);
    check("arsize_burst", {arsize, arburst, arlock, arcache}, {3'b011, 2'b01, 1'b0, 4'b0});
  endtask

  // Serve one burst as the AXI slave; the caller has already set requests.
  task automatic serve(input bit dm, input logic [63:0] a, input logic [7:0] l,
                       input int ar_delay, input int exp_lat, input int nbeats,
                       input logic [12:0] beat_id, input int rst_beat);
    int n = 0;
    logic [63:0] d;
    logic [1:0]  r;
    do begin
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b0;
      #1; n++;
    end while (!arvalid && n < 20);
    check("ar_latency", 64'(n), 64'(exp_lat));
    for (int i = 0; i < ar_delay; i++) begin
      chk_ar(dm, a, l);
      check("gnt_stall", {if_gnt, dm_gnt}, 64'd0);
      @(negedge clk); #1;
    end
    chk_ar(dm, a, l);
    arready = 1'b1;
    #1;
    check("gnt", {if_gnt, dm_gnt}, dm ? 64'b01 : 64'b10);
    last_was_if = !dm;
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b0;
        if (dm) dm_req = 1'b0; else if_req = 1'b0;
        #1;
        check("gap_rvalid", {if_rvalid, dm_rvalid}, 64'd0);
        check("gap_rready", 64'(rready), 64'd1);
      end
      @(negedge clk);
      arready = 1'b0;
      if (dm) dm_req = 1'b0; else if_req = 1'b0;
      d = {$urandom, $urandom};
      r = 2'($urandom);
      rdata = d; rresp = r; rid = beat_id;
      rlast = (b == nbeats - 1);
      rvalid = 1'b1;
      if (b == rst_beat) begin
        reset = 1'b1;
        #1;
        chk_quiet("rst_mid");
        check("rst_mid_perr", 64'(proto_err), 64'd0);
        last_was_if = 1'b1;
        @(negedge clk);
        reset = 1'b0; rvalid = 1'b0;
        return;
      end
      #1;
      check("rvalid_route", {if_rvalid, dm_rvalid}, dm ? 64'b01 : 64'b10);
      check("rready", 64'(rready), 64'd1);
      check("rdata", dm ? dm_rdata : if_rdata, d);
      check("rresp", 64'(dm ? dm_rresp : if_rresp), 64'(r));
      check("rlast", 64'(dm ? dm_rlast : if_rlast), 64'(b == nbeats - 1));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; rvalid = 1'b0; arready = 1'b0;
    #1;
    check("rst_perr", 64'(proto_err), 64'd0);
    last_was_if = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    bit wi, wd, w;
    logic [63:0] ai, ad;
    logic [7:0]  li, ld;
    reset = 1'b1;
    if_req = 0; dm_req = 0; if_addr = 0; dm_addr = 0; if_len = 0; dm_len = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    @(negedge clk); #1;
    chk_quiet("reset");
    check("reset_perr", 64'(proto_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Single fetch burst
    if_req = 1; if_addr = 64'h8000_0000; if_len = 8'd7;
    serve(0, 64'h8000_0000, 8'd7, 2, 1, 8, 13'd0, -1);
    idle_cycle();
    check("fetch_idle_rready", 64'(rready), 64'd0);
    check("fetch_idle_arvalid", 64'(arvalid), 64'd0);
    check("fetch_perr", 64'(proto_err), 64'd0);

    // Two back-to-back ties: winner from the policy, loser served next
    repeat (2) begin
      if_req = 1; if_addr = 64'h1000; if_len = 8'd1;
      dm_req = 1; dm_addr = 64'h2000; dm_len = 8'd2;
      w = model_pick_dm(1'b1, 1'b1);
      if (w) serve(1, 64'h2000, 8'd2, 0, 1, 3, 13'd1, -1);
      else   serve(0, 64'h1000, 8'd1, 0, 1, 2, 13'd0, -1);
      if (w) serve(0, 64'h1000, 8'd1, 0, 2, 2, 13'd0, -1);
      else   serve(1, 64'h2000, 8'd2, 0, 2, 3, 13'd1, -1);
      idle_cycle();
    end

    // AR stall of 5 cycles
    dm_req = 1; dm_addr = 64'hdead_beef_0000_0040; dm_len = 8'd3;
    serve(1, 64'hdead_beef_0000_0040, 8'd3, 5, 1, 4, 13'd1, -1);
    idle_cycle();

    // Random traffic
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      wi = 1'($urandom); wd = 1'($urandom);
      if (!wi && !wd) wi = 1;
      ai = {$urandom, $urandom}; ad = {$urandom, $urandom};
      li = 8'($urandom_range(0, 5)); ld = 8'($urandom_range(0, 5));
      if_req = wi; if_addr = ai; if_len = li;
      dm_req = wd; dm_addr = ad; dm_len = ld;
      w = model_pick_dm(wi, wd);
      if (w) serve(1, ad, ld, $urandom_range(0, 3), 1, int'(ld) + 1, 13'd1, -1);
      else   serve(0, ai, li, $urandom_range(0, 3), 1, int'(li) + 1, 13'd0, -1);
      if (wi && wd) begin
        if (w) serve(0, ai, li, $urandom_range(0, 3), 2, int'(li) + 1, 13'd0, -1);
        else   serve(1, ad, ld, $urandom_range(0, 3), 2, int'(ld) + 1, 13'd1, -1);
      end
      idle_cycle();
    end
    check("random_perr", 64'(proto_err), 64'd0);

    // Stray rvalid in IDLE is ignored
    @(negedge clk);
    rvalid = 1'b1; rlast = 1'b1; rid = 13'd7;
    #1;
    check("stray_rready", 64'(rready), 64'd0);
    check("stray_rvalid", {if_rvalid, dm_rvalid}, 64'd0);
    idle_cycle();
    check("stray_perr", 64'(proto_err), 64'd0);

    // Early rlast: len 3, rlast on the third beat
    dm_req = 1; dm_addr = 64'h300; dm_len = 8'd3;
    serve(1, 64'h300, 8'd3, 0, 1, 3, 13'd1, -1);
    idle_cycle();
    check("early_perr", 64'(proto_err), 64'd1);
    check("early_idle_rready", 64'(rready), 64'd0);
    if_req = 1; if_addr = 64'h400; if_len = 8'd0;
    serve(0, 64'h400, 8'd0, 0, 1, 1, 13'd0, -1);
    idle_cycle();
    check("early_perr_sticky", 64'(proto_err), 64'd1);

    // RID mismatch
    pulse_reset();
    if_req = 1; if_addr = 64'h500; if_len = 8'd1;
    serve(0, 64'h500, 8'd1, 1, 1, 2, 13'd5, -1);
    idle_cycle();
    check("rid_perr", 64'(proto_err), 64'd1);

    // Missing rlast: len 1 but rlast only on the third beat
    pulse_reset();
    dm_req = 1; dm_addr = 64'h600; dm_len = 8'd1;
    serve(1, 64'h600, 8'd1, 0, 1, 3, 13'd1, -1);
    idle_cycle();
    check("late_perr", 64'(proto_err), 64'd1);

    // Reset during beat 3 of 8, then a normal burst
    if_req = 1; if_addr = 64'h700; if_len = 8'd7;
    serve(0, 64'h700, 8'd7, 0, 1, 8, 13'd0, 2);
    if_req = 1; if_addr = 64'h800; if_len = 8'd2;
    serve(0, 64'h800, 8'd2, 1, 1, 3, 13'd0, -1);
    idle_cycle();
    check("post_rst_perr", 64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
